// File: rtl/cmlk_3d_img_packer.sv
// cmlk_3d_img_packer
// Packetizer behind the 16->32 repacker. Incoming words are buffered in a
// FIFO. Once a full packet is buffered, the block sends one header word
// {SYNC_WORD, pkt_seq} and then PKT_WORDS payload words. m_axis_tlast marks
// the final payload word.
//
// Handshake: a word transfers on a rising clk edge where m_axis_tvalid and
// m_axis_tready are both 1. While tvalid=1 and tready=0, tdata, tlast and
// tvalid do not change. tvalid only falls after a handshake. The din side has
// no back-pressure; words that arrive while the FIFO is full are dropped and
// flagged on ovf.
module cmlk_3d_img_packer #(
  parameter int          PKT_WORDS  = 256,
  parameter int          FIFO_DEPTH = 512,
  parameter logic [15:0] SYNC_WORD  = 16'hCA3D
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   din,
  input  logic                          din_vld,
  input  logic                          clr_ovf,
  output logic [31:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(PKT_WORDS);
  localparam logic [CW-1:0] PKT_CNT  = CW'(PKT_WORDS);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(PKT_WORDS - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [PW-1:0] pay_cnt;
  logic [15:0]   pkt_seq;

  logic          full;
  logic          wr_en;
  logic          drop;
  logic          hs;
  logic          load_hdr;
  logic          load_pay;
  logic          end_pkt;

  // Full is judged on the registered count, so a same-cycle pop never makes room.
  assign full  = (fifo_cnt == FULL_CNT);
  assign wr_en = din_vld & ~full;
  assign drop  = din_vld & full;
  assign hs    = m_axis_tvalid & m_axis_tready;

  assign dbg_state = state;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: start only once a whole packet is buffered.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_cnt >= PKT_CNT) state_nxt = HDR;
      HDR:     if (hs) state_nxt = PAY;
      PAY:     if (hs && m_axis_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: header load, payload prefetch into the output register, end of packet.
  always_comb begin
    load_hdr = 1'b0;
    load_pay = 1'b0;
    end_pkt  = 1'b0;
    case (state)
      HDR: begin
        load_hdr = ~m_axis_tvalid;
        load_pay = hs;
      end
      PAY: begin
        load_pay = hs & ~m_axis_tlast;
        end_pkt  = hs & m_axis_tlast;
      end
      default: ;
    endcase
  end

  // FIFO storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // FIFO pointers and occupancy; a payload word is popped as it enters the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
      if (load_pay) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, load_pay})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sticky overflow flag; a drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (clr_ovf) ovf <= 1'b0;
  end

  // Registered AXI-Stream output word, payload counter and packet sequence number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      pay_cnt       <= '0;
      pkt_seq       <= '0;
    end else if (load_hdr) begin
      m_axis_tdata  <= {SYNC_WORD, pkt_seq};
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= 1'b0;
      pay_cnt       <= '0;
    end else if (load_pay) begin
      m_axis_tdata  <= mem[rd_ptr];
      m_axis_tvalid <= 1'b1;
      // A payload handshake (state PAY) has just finished word pay_cnt.
      // The next word loaded is the last one when pay_cnt is PKT_WORDS-2.
      m_axis_tlast  <= (state == PAY) && (pay_cnt == LAST_IDX);
      if (state == PAY) pay_cnt <= pay_cnt + 1'b1;
    end else if (end_pkt) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      pay_cnt       <= '0;
      pkt_seq       <= pkt_seq + 16'd1;
    end
  end

endmodule
